sdp_dist_ram_param: RTL

Parametrised simple-dual-port distributed RAM for Xilinx 7-series CLB LUT-RAM, succeeding the fixed 256x8 single-port part. It provides one write port and one independent read port, per-byte write enables, a selectable asynchronous or registered read path, and a hardware clear sequencer that zeroes every location after reset. It sits beside datapath blocks that need small, fast scratch storage with a known post-reset state.

---
 rtl/sdp_dist_ram_param.sv | 116 +++++++++++
 1 files changed

// File: rtl/sdp_dist_ram_param.sv
// Simple-dual-port LUT RAM with byte-lane writes and a post-reset zero-fill sequencer.
// Latency: write visible after the accepting edge; read 0 cycles (RD_REG=0) or 1 cycle (RD_REG=1).
// Backpressure: none; writes arriving while the clear runs are dropped and flagged on wr_drop_out.
module sdp_dist_ram_param #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int BYTE_W       = 8,
    parameter int RD_REG       = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       write_en,
    input  logic [ADDR_W-1:0]          wr_address_in,
    input  logic [DATA_W/BYTE_W-1:0]   byte_en_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd_en_in,
    input  logic [ADDR_W-1:0]          rd_address_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid_out,
    output logic                       busy_out,
    output logic                       wr_drop_out
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    // Counter is one bit wider than the address so the last-address compare never wraps.
    localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CLR_STEP = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t ST_RESET = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   clr_cnt_q;
    logic [ADDR_W:0]   clr_cnt_d;
    logic              wr_drop_q;
    logic              busy;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_RESET;
            clr_cnt_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_drop_q <= write_en & busy;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + CLR_STEP;
            if (clr_cnt_q == CLR_LAST) begin
                state_d = ST_READY;
            end
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign wr_accept = write_en & ~busy;

    // One narrow array per lane keeps each lane a plain LUT-RAM with its own write enable.
    for (genvar l = 0; l < NB; l++) begin : g_lane
        logic [BYTE_W-1:0] lane_mem [DEPTH];

        always_ff @(posedge clk_in) begin
            if (busy) begin
                lane_mem[clr_cnt_q[ADDR_W-1:0]] <= '0;
            end else if (wr_accept && byte_en_in[l]) begin
                lane_mem[wr_address_in] <= data_in[l*BYTE_W +: BYTE_W];
            end
        end

        assign rd_word[l*BYTE_W +: BYTE_W] = lane_mem[rd_address_in];
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [DATA_W-1:0] rd_dat_q;
        logic              rd_vld_q;

        // Sampling the array before the edge's write lands gives read-first behaviour.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                rd_dat_q <= '0;
                rd_vld_q <= 1'b0;
            end else if (rd_en_in && !busy) begin
                rd_dat_q <= rd_word;
                rd_vld_q <= 1'b1;
            end else begin
                rd_vld_q <= 1'b0;
            end
        end

        assign data_out     = rd_dat_q;
        assign rd_valid_out = rd_vld_q;
    end else begin : g_rd_async
        assign data_out     = busy ? '0 : rd_word;
        assign rd_valid_out = rd_en_in & ~busy;
    end

    assign busy_out    = busy;
    assign wr_drop_out = wr_drop_q;

endmodule
